test_scheduler: RTL and testbench

Sequencer for the regression harness. It runs N self-checking test instances one at a time, each with its own `clock`/`reset`/`fail`/`finish`. For each test it drives a private reset, runs it under a watchdog, and records pass, fail or timeout. It then raises a single `done`/`pass` summary for the top-level bench to act on. Per-test reset isolation means a hung or failing test cannot mask the others, and the summary width always matches the number of tests.

---
 rtl/test_scheduler.sv | 166 ++++++++++++++++
 tb/tb_test_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_scheduler.sv
// -----------------------------------------------------------------------------
// test_scheduler
//
// Runs N self-checking test instances one at a time. Each test is held in a
// private reset for RST_CYCLES cycles and then released to run under a
// watchdog. The scheduler records whether the test passed, failed or timed
// out, and after the last test it raises a done/pass summary.
//
// Parameters
//   N            number of test instances (1..64)
//   RST_CYCLES   cycles each test is held in reset before it runs (>=1)
//   TIMEOUT      maximum RUN cycles per test before a timeout (>=2)
//   STOP_ON_FAIL 1 = end the sweep at the first failure or timeout
//
// Ports
//   clock        single clock for the scheduler and all tests
//   reset        synchronous, active-high
//   start        level; starts a sweep when sampled in IDLE or DONE
//   fail         per-test fail flags (only the active test's bit is used)
//   finish       per-test finish flags (only the active test's bit is used)
//   test_reset   per-test synchronous resets, active-high
//   active       index of the current test
//   busy         high while a sweep is in progress (LAUNCH, RUN, NEXT)
//   done         high once the sweep has ended
//   pass         high in DONE when no test failed or timed out
//   fail_mask    bit i set when test i failed or timed out
//   timeout_mask bit i set when test i timed out (subset of fail_mask)
// -----------------------------------------------------------------------------
module test_scheduler #(
  parameter int N            = 14,
  parameter int RST_CYCLES   = 16,
  parameter int TIMEOUT      = 4096,
  parameter int STOP_ON_FAIL = 0,
  localparam int IW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  fail,
  input  logic [N-1:0]  finish,
  output logic [N-1:0]  test_reset,
  output logic [IW-1:0] active,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [N-1:0]  fail_mask,
  output logic [N-1:0]  timeout_mask
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [RW-1:0] rcnt_reg, rcnt_next;
  logic [WW-1:0] wdog_reg, wdog_next;
  logic [N-1:0]  fail_mask_reg, fail_mask_next;
  logic [N-1:0]  timeout_mask_reg, timeout_mask_next;

  logic stop_on_fail;
  assign stop_on_fail = (STOP_ON_FAIL != 0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      idx_reg          <= '0;
      rcnt_reg         <= '0;
      wdog_reg         <= '0;
      fail_mask_reg    <= '0;
      timeout_mask_reg <= '0;
    end else begin
      state_reg        <= state_next;
      idx_reg          <= idx_next;
      rcnt_reg         <= rcnt_next;
      wdog_reg         <= wdog_next;
      fail_mask_reg    <= fail_mask_next;
      timeout_mask_reg <= timeout_mask_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    idx_next          = idx_reg;
    rcnt_next         = rcnt_reg;
    wdog_next         = wdog_reg;
    fail_mask_next    = fail_mask_reg;
    timeout_mask_next = timeout_mask_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        // A new sweep always begins from test 0 with clean masks.
        if (start) begin
          state_next        = S_LAUNCH;
          idx_next          = '0;
          rcnt_next         = '0;
          fail_mask_next    = '0;
          timeout_mask_next = '0;
        end
      end

      S_LAUNCH: begin
        rcnt_next = rcnt_reg + 1'b1;
        if (rcnt_reg == RW'(RST_CYCLES - 1)) begin
          state_next = S_RUN;
          wdog_next  = '0;
        end
      end

      S_RUN: begin
        // fail outranks finish, and any flag outranks the watchdog, so a
        // flag on the last watchdog cycle is still honoured.
        if (fail[idx_reg]) begin
          fail_mask_next[idx_reg] = 1'b1;
          state_next = stop_on_fail ? S_DONE : S_NEXT;
        end else if (finish[idx_reg]) begin
          state_next = S_NEXT;
        end else if (wdog_reg == WW'(TIMEOUT - 1)) begin
          fail_mask_next[idx_reg]    = 1'b1;
          timeout_mask_next[idx_reg] = 1'b1;
          state_next = stop_on_fail ? S_DONE : S_NEXT;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end

      S_NEXT: begin
        if (idx_reg == IW'(N - 1)) begin
          state_next = S_DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          rcnt_next  = '0;
          state_next = S_LAUNCH;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Only the active test is ever released, and only while in RUN; every
  // other test (and every test in every other state) is held in reset.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_test_reset
      assign test_reset[gi] = !((state_reg == S_RUN) && (idx_reg == IW'(gi)));
    end
  endgenerate

  assign active       = idx_reg;
  assign busy         = (state_reg == S_LAUNCH) || (state_reg == S_RUN) ||
                        (state_reg == S_NEXT);
  assign done         = (state_reg == S_DONE);
  assign pass         = (state_reg == S_DONE) && (fail_mask_reg == '0);
  assign fail_mask    = fail_mask_reg;
  assign timeout_mask = timeout_mask_reg;

endmodule

// File: tb/tb_test_scheduler.sv
// -----------------------------------------------------------------------------
// tb_test_scheduler
//
// Bench for test_scheduler with N=4, RST_CYCLES=2, TIMEOUT=16. Each of the
// four test instances is emulated: while its test_reset is high it drives
// random garbage on fail/finish, and once released it raises its configured
// flag(s) on RUN cycle k. Expected sweep results come from a hand table and
// from a spec-level model (per test: flag before the watchdog expires or
// timeout; sweep length = sum of RST_CYCLES + RUN cycles + 1). A second
// instance with STOP_ON_FAIL=1 covers the early-exit behaviour.
// -----------------------------------------------------------------------------
module tb_test_scheduler;

  localparam int N   = 4;
  localparam int RST = 2;
  localparam int TO  = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] fail, finish;
  logic [3:0] test_reset;
  logic [1:0] active;
  logic       busy, done, pass;
  logic [3:0] fail_mask, timeout_mask;

  logic       start_s;
  logic [3:0] fail_s, finish_s;
  logic [3:0] test_reset_s;
  logic [1:0] active_s;
  logic       busy_s, done_s, pass_s;
  logic [3:0] fail_mask_s, timeout_mask_s;

  always #5 clock = ~clock;

  test_scheduler #(.N(N), .RST_CYCLES(RST), .TIMEOUT(TO), .STOP_ON_FAIL(0)) dut (
    .clock(clock), .reset(reset), .start(start), .fail(fail), .finish(finish),
    .test_reset(test_reset), .active(active), .busy(busy), .done(done),
    .pass(pass), .fail_mask(fail_mask), .timeout_mask(timeout_mask)
  );

  test_scheduler #(.N(N), .RST_CYCLES(RST), .TIMEOUT(TO), .STOP_ON_FAIL(1)) dut_s (
    .clock(clock), .reset(reset), .start(start_s), .fail(fail_s), .finish(finish_s),
    .test_reset(test_reset_s), .active(active_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .fail_mask(fail_mask_s), .timeout_mask(timeout_mask_s)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- test emulation
  // beh_kind: bit1 = raise fail, bit0 = raise finish, on RUN cycle beh_k.
  int beh_kind[4];
  int beh_k[4];
  int cur[4];
  int runlen[4];
  int badlow = 0;

  initial begin
    for (int j = 0; j < 4; j++) begin
      beh_kind[j] = 1; beh_k[j] = 0; cur[j] = 0; runlen[j] = 0;
    end
    fail = '0;
    finish = '0;
  end

  always @(negedge clock) begin
    if ($countones(~test_reset) > 1) badlow++;
    for (int j = 0; j < 4; j++) begin
      if (test_reset[j] === 1'b0) begin
        fail[j]   = (cur[j] == beh_k[j]) && beh_kind[j][1];
        finish[j] = (cur[j] == beh_k[j]) && beh_kind[j][0];
        cur[j]++;
        runlen[j]++;
      end else begin
        cur[j]    = 0;
        fail[j]   = 1'($urandom);
        finish[j] = 1'($urandom);
      end
    end
  end

  // ---------------------------------------------------------------- reference model
  logic [3:0] m_fm, m_tm;
  logic       m_pass;
  int         m_total;
  int         m_runs[4];

  task automatic model();
    m_fm = '0; m_tm = '0; m_total = 0;
    for (int j = 0; j < 4; j++) begin
      if (beh_kind[j] != 0 && beh_k[j] < TO) begin
        m_runs[j] = beh_k[j] + 1;
        if (beh_kind[j] >= 2) m_fm[j] = 1'b1;
      end else begin
        m_runs[j] = TO;
        m_fm[j] = 1'b1;
        m_tm[j] = 1'b1;
      end
      m_total += RST + m_runs[j] + 1;
    end
    m_pass = (m_fm == 4'b0000);
  endtask

  task automatic load(input logic [7:0] kinds, input logic [19:0] ks);
    for (int j = 0; j < 4; j++) begin
      beh_kind[j] = int'(kinds[2*j +: 2]);
      beh_k[j]    = int'(ks[5*j +: 5]);
    end
  endtask

  // One full sweep: start, wait for done, compare the summary.
  task automatic sweep(input string name, input logic [3:0] efm, input logic [3:0] etm,
                       input logic epass, input int etotal);
    int n;
    int base[4];
    int bl;
    @(negedge clock);
    for (int j = 0; j < 4; j++) base[j] = runlen[j];
    bl = badlow;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk({name, "_clr_fm"}, 64'(fail_mask), 64'(0));
    chk({name, "_busy"}, 64'(busy), 64'(1));
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, "_cycles"}, 64'(n), 64'(etotal));
    chk({name, "_fm"}, 64'(fail_mask), 64'(efm));
    chk({name, "_tm"}, 64'(timeout_mask), 64'(etm));
    chk({name, "_pass"}, 64'(pass), 64'(epass));
    chk({name, "_busy_done"}, 64'(busy), 64'(0));
    chk({name, "_active"}, 64'(active), 64'(N - 1));
    for (int j = 0; j < 4; j++)
      chk($sformatf("%s_runs%0d", name, j), 64'(runlen[j] - base[j]), 64'(m_runs[j]));
    chk({name, "_onehot_release"}, 64'(badlow - bl), 64'(0));
    $display("sweep %s: cycles=%0d fail_mask=%b timeout_mask=%b pass=%b",
             name, n, fail_mask, timeout_mask, pass);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    string       name;
    logic [7:0]  kinds;   // {t3,t2,t1,t0}, 2 bits each
    logic [19:0] ks;      // {t3,t2,t1,t0}, 5 bits each
    logic [3:0]  efm;
    logic [3:0]  etm;
    logic        epass;
    int          etotal;
  } vec_t;

  vec_t vec[7];

  initial begin
    int n;
    vec[0] = '{"all_pass",    8'b01_01_01_01, {5'd3, 5'd3, 5'd3, 5'd3},   4'b0000, 4'b0000, 1'b1, 28};
    vec[1] = '{"single_fail", 8'b01_10_01_01, {5'd3, 5'd0, 5'd3, 5'd3},   4'b0100, 4'b0000, 1'b0, 25};
    vec[2] = '{"timeout1",    8'b01_01_00_01, {5'd3, 5'd3, 5'd0, 5'd3},   4'b0010, 4'b0010, 1'b0, 40};
    vec[3] = '{"late_finish", 8'b01_01_01_01, {5'd3, 5'd3, 5'd15, 5'd3},  4'b0000, 4'b0000, 1'b1, 40};
    vec[4] = '{"both_flags",  8'b11_01_01_01, {5'd5, 5'd3, 5'd3, 5'd3},   4'b1000, 4'b0000, 1'b0, 30};
    vec[5] = '{"fail_late",   8'b01_01_01_10, {5'd0, 5'd0, 5'd0, 5'd16},  4'b0001, 4'b0001, 1'b0, 31};
    vec[6] = '{"mixed",       8'b01_11_00_10, {5'd0, 5'd15, 5'd0, 5'd7},  4'b0111, 4'b0010, 1'b0, 53};

    reset = 1'b1; start = 1'b0;
    start_s = 1'b0; fail_s = '0; finish_s = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_test_reset", 64'(test_reset), 64'(4'b1111));
    chk("rst_active", 64'(active), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_pass", 64'(pass), 64'(0));
    chk("rst_fm", 64'(fail_mask), 64'(0));
    chk("rst_tm", 64'(timeout_mask), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    // Table-driven sweeps (each after the first restarts from DONE).
    for (int v = 0; v < 7; v++) begin
      load(vec[v].kinds, vec[v].ks);
      model();
      sweep(vec[v].name, vec[v].efm, vec[v].etm, vec[v].epass, vec[v].etotal);
    end

    // Randomized sweeps against the model.
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < 4; j++) begin
        beh_kind[j] = int'($urandom_range(0, 3));
        beh_k[j]    = int'($urandom_range(0, 17));
      end
      model();
      sweep($sformatf("rand%0d", r), m_fm, m_tm, m_pass, m_total);
    end

    // Reset during test 1 RUN, after test 0 has already failed.
    load(8'b01_01_00_10, {5'd3, 5'd3, 5'd0, 5'd0});
    @(negedge clock);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (test_reset[1] !== 1'b0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("midrst_reach_run1", 64'(test_reset), 64'(4'b1101));
    repeat (3) begin @(posedge clock); #1; end
    chk("midrst_pre_fm", 64'(fail_mask), 64'(4'b0001));
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("midrst_test_reset", 64'(test_reset), 64'(4'b1111));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_active", 64'(active), 64'(0));
    chk("midrst_fm", 64'(fail_mask), 64'(0));
    chk("midrst_tm", 64'(timeout_mask), 64'(0));
    $display("reset mid-sweep: test_reset=%b fail_mask=%b", test_reset, fail_mask);
    @(negedge clock);
    reset = 1'b0;
    load(vec[0].kinds, vec[0].ks);
    model();
    sweep("after_reset", vec[0].efm, vec[0].etm, vec[0].epass, vec[0].etotal);

    // Stop-on-fail: test 0 fails on RUN cycle 0.
    @(negedge clock);
    start_s = 1'b1;
    @(posedge clock); #1;
    start_s = 1'b0;
    chk("sof_busy", 64'(busy_s), 64'(1));
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("sof_run0_release", 64'(test_reset_s), 64'(4'b1110));
    @(negedge clock);
    fail_s = 4'b0011;
    @(posedge clock); #1;
    chk("sof_done", 64'(done_s), 64'(1));
    chk("sof_active", 64'(active_s), 64'(0));
    chk("sof_fm", 64'(fail_mask_s), 64'(4'b0001));
    chk("sof_tm", 64'(timeout_mask_s), 64'(4'b0000));
    chk("sof_pass", 64'(pass_s), 64'(0));
    $display("stop_on_fail fail: done=%b active=%0d fail_mask=%b", done_s, active_s, fail_mask_s);
    @(negedge clock);
    fail_s = '0;
    n = 0;
    repeat (5) begin
      @(posedge clock); #1;
      if (test_reset_s[1] !== 1'b1) n++;
    end
    chk("sof_test1_held", 64'(n), 64'(0));

    // Stop-on-fail: test 0 never flags -> timeout ends the sweep.
    @(negedge clock);
    start_s = 1'b1;
    @(posedge clock); #1;
    start_s = 1'b0;
    chk("sof_to_clr_fm", 64'(fail_mask_s), 64'(0));
    n = 0;
    while (!done_s && n < 500) begin
      @(posedge clock); #1;
      n++;
    end
    chk("sof_to_cycles", 64'(n), 64'(RST + TO));
    chk("sof_to_fm", 64'(fail_mask_s), 64'(4'b0001));
    chk("sof_to_tm", 64'(timeout_mask_s), 64'(4'b0001));
    chk("sof_to_active", 64'(active_s), 64'(0));
    $display("stop_on_fail timeout: cycles=%0d timeout_mask=%b", n, timeout_mask_s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
